// File: rtl/core_pkg.sv
// Shared core constants: register-file geometry, result-bus count, issue-lane indices and
// the operand read helper used by the register-read stage.
package core_pkg;

   localparam int unsigned PR_W   = 6;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned NUM_PR = 64;
   localparam int unsigned NUM_WB = 4;

   localparam int unsigned LANE_ALU0 = 0;
   localparam int unsigned LANE_ALU1 = 1;
   localparam int unsigned LANE_AGU  = 2;
   localparam int unsigned LANE_BRU  = 3;

   // Result-bus bypass priority, highest first; several hits on one PR should never happen.
   localparam int unsigned WB_PRIO [NUM_WB] = '{LANE_ALU0, LANE_ALU1, LANE_AGU, LANE_BRU};

   function automatic logic [DATA_W-1:0] read_operand(
      input logic [NUM_PR*DATA_W-1:0] rf_flat,
      input logic [NUM_WB-1:0]        wb_vld,
      input logic [NUM_WB*PR_W-1:0]   wb_pr,
      input logic [NUM_WB*DATA_W-1:0] wb_data,
      input logic [PR_W-1:0]          pr
   );
      logic [DATA_W-1:0] val;
      logic              hit;
      val = rf_flat[pr*DATA_W +: DATA_W];
      hit = 1'b0;
      for (int i = 0; i < NUM_WB; i++) begin
         if (!hit && wb_vld[WB_PRIO[i]] && (wb_pr[WB_PRIO[i]*PR_W +: PR_W] == pr)) begin
            val = wb_data[WB_PRIO[i]*DATA_W +: DATA_W];
            hit = 1'b1;
         end
      end
      // PR0 is hardwired zero, even if some bus claims to write it.
      if (pr == '0) begin
         val = '0;
      end
      return val;
   endfunction

endpackage

// File: rtl/rf_read_lane.sv
// One issue lane of the register-read stage: operand fetch with result-bus bypass, then an
// output register backed by a one-entry skid buffer so in_rdy never depends on out_rdy.
module rf_read_lane
   import core_pkg::*;
#(
   parameter int unsigned PAYLOAD_W = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [NUM_PR*DATA_W-1:0]   rf_flat,
   input  logic [NUM_WB-1:0]          wb_vld,
   input  logic [NUM_WB*PR_W-1:0]     wb_pr,
   input  logic [NUM_WB*DATA_W-1:0]   wb_data,
   input  logic                       in_vld,
   output logic                       in_rdy,
   input  logic [PR_W-1:0]            in_src1_pr,
   input  logic [PR_W-1:0]            in_src2_pr,
   input  logic [PAYLOAD_W-1:0]       in_payload,
   output logic                       out_vld,
   input  logic                       out_rdy,
   output logic [DATA_W-1:0]          out_src1,
   output logic [DATA_W-1:0]          out_src2,
   output logic [PAYLOAD_W-1:0]       out_payload
);

   typedef struct packed {
      logic [DATA_W-1:0]    src1;
      logic [DATA_W-1:0]    src2;
      logic [PAYLOAD_W-1:0] payload;
   } uop_t;

   uop_t in_uop;
   uop_t out_d, out_q;
   uop_t skid_d, skid_q;
   logic out_vld_d, out_vld_q;
   logic skid_vld_d, skid_vld_q;
   logic accept, fire;

   always_comb begin
      in_uop.src1    = read_operand(rf_flat, wb_vld, wb_pr, wb_data, in_src1_pr);
      in_uop.src2    = read_operand(rf_flat, wb_vld, wb_pr, wb_data, in_src2_pr);
      in_uop.payload = in_payload;
   end

   assign in_rdy = ~skid_vld_q;
   assign accept = in_vld & in_rdy;
   assign fire   = out_vld_q & out_rdy;

   always_comb begin
      out_vld_d  = out_vld_q;
      skid_vld_d = skid_vld_q;
      out_d      = out_q;
      skid_d     = skid_q;
      if (flush) begin
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (skid_vld_q) begin
         // in_rdy is low, so nothing new can arrive; the skid entry drains first.
         if (fire) begin
            out_d      = skid_q;
            skid_vld_d = 1'b0;
         end
      end else if (accept) begin
         if (out_vld_q && !out_rdy) begin
            skid_d     = in_uop;
            skid_vld_d = 1'b1;
         end else begin
            out_d     = in_uop;
            out_vld_d = 1'b1;
         end
      end else if (fire) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_vld_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         out_q      <= '0;
         skid_q     <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         skid_vld_q <= skid_vld_d;
         out_q      <= out_d;
         skid_q     <= skid_d;
      end
   end

   assign out_vld     = out_vld_q;
   assign out_src1    = out_q.src1;
   assign out_src2    = out_q.src2;
   assign out_payload = out_q.payload;

endmodule

// File: rtl/regfile_read_stage.sv
// Register-read stage top: one independent rf_read_lane per issue lane (ALU0, ALU1, AGU, BRU),
// sharing the regfile image and result buses.
module regfile_read_stage
   import core_pkg::*;
#(
   parameter int unsigned LANES     = 4,
   parameter int unsigned PAYLOAD_W = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic [NUM_PR*DATA_W-1:0]     rf_flat,
   input  logic [NUM_WB-1:0]            wb_vld,
   input  logic [NUM_WB*PR_W-1:0]       wb_pr,
   input  logic [NUM_WB*DATA_W-1:0]     wb_data,
   input  logic [LANES-1:0]             in_vld,
   output logic [LANES-1:0]             in_rdy,
   input  logic [LANES*PR_W-1:0]        in_src1_pr,
   input  logic [LANES*PR_W-1:0]        in_src2_pr,
   input  logic [LANES*PAYLOAD_W-1:0]   in_payload,
   output logic [LANES-1:0]             out_vld,
   input  logic [LANES-1:0]             out_rdy,
   output logic [LANES*DATA_W-1:0]      out_src1,
   output logic [LANES*DATA_W-1:0]      out_src2,
   output logic [LANES*PAYLOAD_W-1:0]   out_payload
);

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      rf_read_lane #(
         .PAYLOAD_W (PAYLOAD_W)
      ) u_lane (
         .clk         (clk),
         .rst         (rst),
         .flush       (flush),
         .rf_flat     (rf_flat),
         .wb_vld      (wb_vld),
         .wb_pr       (wb_pr),
         .wb_data     (wb_data),
         .in_vld      (in_vld[i]),
         .in_rdy      (in_rdy[i]),
         .in_src1_pr  (in_src1_pr[i*PR_W +: PR_W]),
         .in_src2_pr  (in_src2_pr[i*PR_W +: PR_W]),
         .in_payload  (in_payload[i*PAYLOAD_W +: PAYLOAD_W]),
         .out_vld     (out_vld[i]),
         .out_rdy     (out_rdy[i]),
         .out_src1    (out_src1[i*DATA_W +: DATA_W]),
         .out_src2    (out_src2[i*DATA_W +: DATA_W]),
         .out_payload (out_payload[i*PAYLOAD_W +: PAYLOAD_W])
      );
   end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Bench for regfile_read_stage: directed scenarios with literal expectations, then random
// all-lane traffic checked every cycle against a per-lane two-slot FIFO occupancy model.
module tb_regfile_read_stage;

   localparam int L   = 4;
   localparam int PW  = 6;
   localparam int DW  = 32;
   localparam int YW  = 64;
   localparam int NPR = 64;
   localparam int NWB = 4;

   logic clk = 1'b0;
   logic rst, flush;
   logic [NPR*DW-1:0] rf_flat;
   logic [NWB-1:0]    wb_vld;
   logic [NWB*PW-1:0] wb_pr;
   logic [NWB*DW-1:0] wb_data;
   logic [L-1:0]      in_vld, in_rdy, out_vld, out_rdy;
   logic [L*PW-1:0]   in_src1_pr, in_src2_pr;
   logic [L*YW-1:0]   in_payload, out_payload;
   logic [L*DW-1:0]   out_src1, out_src2;

   logic [DW-1:0] rf  [NPR];
   logic [PW-1:0] wbp [NWB];
   logic [DW-1:0] wbd [NWB];
   logic [PW-1:0] s1  [L];
   logic [PW-1:0] s2  [L];
   logic [YW-1:0] pay [L];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int n = 0; n < NPR; n++) rf_flat[n*DW +: DW] = rf[n];
   end
   always_comb begin
      for (int k = 0; k < NWB; k++) begin
         wb_pr[k*PW +: PW]   = wbp[k];
         wb_data[k*DW +: DW] = wbd[k];
      end
   end
   always_comb begin
      for (int l = 0; l < L; l++) begin
         in_src1_pr[l*PW +: PW] = s1[l];
         in_src2_pr[l*PW +: PW] = s2[l];
         in_payload[l*YW +: YW] = pay[l];
      end
   end

   regfile_read_stage dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .rf_flat     (rf_flat),
      .wb_vld      (wb_vld),
      .wb_pr       (wb_pr),
      .wb_data     (wb_data),
      .in_vld      (in_vld),
      .in_rdy      (in_rdy),
      .in_src1_pr  (in_src1_pr),
      .in_src2_pr  (in_src2_pr),
      .in_payload  (in_payload),
      .out_vld     (out_vld),
      .out_rdy     (out_rdy),
      .out_src1    (out_src1),
      .out_src2    (out_src2),
      .out_payload (out_payload)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Operand value as the execute unit must see it.
   function automatic logic [DW-1:0] ref_read(input logic [PW-1:0] pr);
      if (pr == 0) return '0;
      for (int k = 0; k < NWB; k++) begin
         if (wb_vld[k] && wbp[k] == pr) return wbd[k];
      end
      return rf[pr];
   endfunction

   // Each lane holds at most two uops in arrival order; slot 0 is what the output shows.
   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [YW-1:0] p;
   } exp_t;

   exp_t ment [L][2];
   int   mcnt [L];

   initial begin
      for (int l = 0; l < L; l++) mcnt[l] = 0;
      forever begin
         @(negedge clk);
         for (int l = 0; l < L; l++) begin
            check($sformatf("lane%0d out_vld", l), 64'(out_vld[l]), 64'(mcnt[l] > 0));
            check($sformatf("lane%0d in_rdy", l), 64'(in_rdy[l]), 64'(mcnt[l] < 2));
            if (mcnt[l] > 0) begin
               check($sformatf("lane%0d src1", l), 64'(out_src1[l*DW +: DW]), 64'(ment[l][0].a));
               check($sformatf("lane%0d src2", l), 64'(out_src2[l*DW +: DW]), 64'(ment[l][0].b));
               check($sformatf("lane%0d payload", l), out_payload[l*YW +: YW], ment[l][0].p);
            end
         end
         for (int l = 0; l < L; l++) begin
            if (rst || flush) begin
               mcnt[l] = 0;
            end else begin
               logic push, pop;
               exp_t e;
               push = in_vld[l] && (mcnt[l] < 2);
               pop  = (mcnt[l] > 0) && out_rdy[l];
               e.a  = ref_read(s1[l]);
               e.b  = ref_read(s2[l]);
               e.p  = pay[l];
               if (pop) begin
                  ment[l][0] = ment[l][1];
                  mcnt[l]--;
               end
               if (push) begin
                  ment[l][mcnt[l]] = e;
                  mcnt[l]++;
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_vld = '0;
      wb_vld = '0;
      flush  = 1'b0;
   endtask

   initial begin
      rst     = 1'b1;
      out_rdy = '1;
      idle();
      for (int n = 0; n < NPR; n++) rf[n] = $urandom;
      for (int k = 0; k < NWB; k++) begin
         wbp[k] = '0;
         wbd[k] = '0;
      end
      for (int l = 0; l < L; l++) begin
         s1[l]  = '0;
         s2[l]  = '0;
         pay[l] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset out_vld", 64'(out_vld), 64'h0);
      check("reset in_rdy", 64'(in_rdy), 64'hF);

      // Plain read, PR0 reads zero whatever the image holds.
      cyc();
      rf[5] = 32'h11;
      rf[0] = 32'hDEAD;
      in_vld[0] = 1'b1; s1[0] = 6'd5; s2[0] = 6'd0; pay[0] = 64'h100;
      cyc();
      idle();
      check("basic out_vld", 64'(out_vld[0]), 64'h1);
      check("basic src1", 64'(out_src1[0*DW +: DW]), 64'h11);
      check("basic src2", 64'(out_src2[0*DW +: DW]), 64'h0);

      // Same-cycle bypass beats the stale image.
      rf[9] = 32'hAAAA; rf[3] = 32'h33;
      wb_vld[1] = 1'b1; wbp[1] = 6'd9; wbd[1] = 32'h1234;
      in_vld[2] = 1'b1; s1[2] = 6'd9; s2[2] = 6'd3; pay[2] = 64'h200;
      cyc();
      idle();
      check("bypass src1", 64'(out_src1[2*DW +: DW]), 64'h1234);
      check("bypass src2", 64'(out_src2[2*DW +: DW]), 64'h33);

      // Double hit resolves to ALU0; a write aimed at PR0 is ignored.
      wb_vld = 4'b1011;
      wbp[0] = 6'd7; wbd[0] = 32'h1;
      wbp[3] = 6'd7; wbd[3] = 32'h2;
      wbp[1] = 6'd0; wbd[1] = 32'hFFFF;
      in_vld[1] = 1'b1; s1[1] = 6'd7; s2[1] = 6'd0; pay[1] = 64'h300;
      cyc();
      idle();
      check("prio src1", 64'(out_src1[1*DW +: DW]), 64'h1);
      check("pr0 src2", 64'(out_src2[1*DW +: DW]), 64'h0);

      // Backpressure on BRU lane: A in output, B in skid, then both drain in order.
      cyc();
      out_rdy[3] = 1'b0;
      in_vld[3] = 1'b1; s1[3] = 6'd1; s2[3] = 6'd2; pay[3] = 64'hA;
      cyc();
      pay[3] = 64'hB;
      cyc();
      idle();
      check("bp in_rdy low", 64'(in_rdy[3]), 64'h0);
      check("bp hold A", out_payload[3*YW +: YW], 64'hA);
      out_rdy[3] = 1'b1;
      cyc();
      check("bp then B", out_payload[3*YW +: YW], 64'hB);
      check("bp in_rdy back", 64'(in_rdy[3]), 64'h1);
      cyc();
      check("bp drained", 64'(out_vld[3]), 64'h0);

      // Flush with output and skid full plus a new uop offered.
      out_rdy[3] = 1'b0;
      in_vld[3] = 1'b1; pay[3] = 64'hC1;
      cyc();
      pay[3] = 64'hC2;
      cyc();
      check("pre-flush in_rdy", 64'(in_rdy[3]), 64'h0);
      pay[3] = 64'hC3;
      flush = 1'b1;
      cyc();
      idle();
      check("flush out_vld", 64'(out_vld[3]), 64'h0);
      check("flush in_rdy", 64'(in_rdy[3]), 64'h1);
      out_rdy = '1;
      cyc();
      check("flush no emit", 64'(out_vld[3]), 64'h0);

      // Random traffic on every lane, small PR range so bypass hits are frequent.
      for (int c = 0; c < 3000; c++) begin
         in_vld = 4'($urandom);
         wb_vld = 4'($urandom);
         flush  = ($urandom_range(0, 63) == 0);
         for (int l = 0; l < L; l++) begin
            out_rdy[l] = ($urandom_range(0, 3) != 0);
            s1[l]  = 6'($urandom_range(0, 15));
            s2[l]  = 6'($urandom_range(0, 15));
            pay[l] = {$urandom, $urandom};
         end
         for (int k = 0; k < NWB; k++) begin
            wbp[k] = 6'($urandom_range(0, 15));
            wbd[k] = $urandom;
         end
         rf[$urandom_range(0, 15)] = $urandom;
         cyc();
      end
      idle();
      out_rdy = '1;
      repeat (4) cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
